// File: rtl/bp_resolve_queue.sv
// ============================================================================
// Module   : bp_resolve_queue
// Purpose  : In-order queue of predicted branches; checks each against the
//            execute outcome, drives counter-table updates and mispredict flush.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [IDX_W-1:0]         push_idx,
  input  logic [31:0]              push_pc,
  input  logic                     push_taken,
  input  logic [31:0]              push_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     upd_en,
  output logic [IDX_W-1:0]         upd_idx,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] r_mem_idx    [DEPTH];
  logic [31:0]      r_mem_pc     [DEPTH];
  logic             r_mem_taken  [DEPTH];
  logic [31:0]      r_mem_target [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_upd_en;
  logic [IDX_W-1:0] r_upd_idx;
  logic             r_upd_taken;
  logic             r_flush;
  logic [31:0]      r_redirect_pc;
  logic             r_err_underflow;

  logic             w_push;
  logic             w_res;
  logic             w_mispred;
  logic             w_kill;
  logic [IDX_W-1:0] w_head_idx;
  logic [31:0]      w_head_pc;
  logic             w_head_taken;
  logic [31:0]      w_head_target;

  assign w_head_idx    = r_mem_idx[r_rptr];
  assign w_head_pc     = r_mem_pc[r_rptr];
  assign w_head_taken  = r_mem_taken[r_rptr];
  assign w_head_target = r_mem_target[r_rptr];

  // Reset is folded in so the queue reports not-ready while held in reset.
  assign push_ready = !reset && !r_flush && (r_count < CNT_W'(DEPTH));

  assign w_push    = push_valid && push_ready;
  assign w_res     = res_valid && (r_count != '0);
  assign w_mispred = (res_taken != w_head_taken) ||
                     (res_taken && (res_target != w_head_target));
  assign w_kill    = w_res && w_mispred;

  // Payload storage carries no reset; occupancy tracking makes stale data harmless.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_idx[r_wptr]    <= push_idx;
      r_mem_pc[r_wptr]     <= push_pc;
      r_mem_taken[r_wptr]  <= push_taken;
      r_mem_target[r_wptr] <= push_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_upd_en        <= 1'b0;
      r_upd_idx       <= '0;
      r_upd_taken     <= 1'b0;
      r_flush         <= 1'b0;
      r_redirect_pc   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_upd_en <= w_res;
      r_flush  <= w_kill;
      if (w_res) begin
        r_upd_idx   <= w_head_idx;
        r_upd_taken <= res_taken;
      end
      if (w_kill) begin
        // A mispredict squashes everything younger, including a same-cycle push.
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_count       <= '0;
        r_redirect_pc <= res_taken ? res_target : (w_head_pc + 32'd4);
      end else begin
        r_wptr  <= r_wptr + PTR_W'(w_push);
        r_rptr  <= r_rptr + PTR_W'(w_res);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_res);
      end
      if (res_valid && (r_count == '0)) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign upd_en        = r_upd_en;
  assign upd_idx       = r_upd_idx;
  assign upd_taken     = r_upd_taken;
  assign flush         = r_flush;
  assign redirect_pc   = r_redirect_pc;
  assign count         = r_count;
  assign err_underflow = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_bp_resolve_queue.sv
// ============================================================================
// Module   : tb_bp_resolve_queue
// Purpose  : Directed self-checking bench for bp_resolve_queue with a
//            queue-based reference model compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_resolve_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             push_valid;
  logic             push_ready;
  logic [IDX_W-1:0] push_idx;
  logic [31:0]      push_pc;
  logic             push_taken;
  logic [31:0]      push_target;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [2:0]       count;
  logic             err_underflow;

  bp_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_idx(push_idx),
    .push_pc(push_pc), .push_taken(push_taken), .push_target(push_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .count(count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
  } ent_t;

  ent_t             m_q[$];
  logic             m_upd_en, m_upd_taken, m_flush, m_err;
  logic [IDX_W-1:0] m_upd_idx;
  logic [31:0]      m_redir;

  ent_t             n_q[$];
  logic             n_upd_en, n_upd_taken, n_flush, n_err;
  logic [IDX_W-1:0] n_upd_idx;
  logic [31:0]      n_redir;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_upd_en = 0; m_upd_taken = 0; m_flush = 0; m_err = 0;
    m_upd_idx = '0; m_redir = '0;
  endtask

  // Next model state from the current inputs, per the queue's behavioural rules.
  task automatic m_eval();
    bit   rdy, pu, rs, mis;
    ent_t h, e;
    n_q = m_q;
    n_upd_idx = m_upd_idx; n_upd_taken = m_upd_taken; n_redir = m_redir;
    rdy = (m_q.size() < DEPTH) && !m_flush;
    pu  = push_valid && rdy;
    rs  = res_valid && (m_q.size() != 0);
    mis = 0;
    if (rs) begin
      h = m_q[0];
      mis = (res_taken != h.taken) || (res_taken && res_target != h.target);
      n_upd_idx = h.idx;
      n_upd_taken = res_taken;
      if (mis) n_redir = res_taken ? res_target : h.pc + 32'd4;
    end
    n_upd_en = rs;
    n_flush  = rs && mis;
    n_err    = m_err || (res_valid && m_q.size() == 0);
    if (n_flush) n_q.delete();
    else begin
      if (rs) void'(n_q.pop_front());
      if (pu) begin
        e.idx = push_idx; e.pc = push_pc; e.taken = push_taken; e.target = push_target;
        n_q.push_back(e);
      end
    end
  endtask

  task automatic m_apply();
    m_q = n_q;
    m_upd_en = n_upd_en; m_upd_idx = n_upd_idx; m_upd_taken = n_upd_taken;
    m_flush = n_flush; m_redir = n_redir; m_err = n_err;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("push_ready", {31'd0, push_ready}, {31'd0, (m_q.size() < DEPTH) && !m_flush});
      chk("count", {29'd0, count}, m_q.size());
      chk("upd_en", {31'd0, upd_en}, {31'd0, m_upd_en});
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("redirect_pc", redirect_pc, m_redir);
      chk("err_underflow", {31'd0, err_underflow}, {31'd0, m_err});
      if (m_upd_en) begin
        chk("upd_idx", {26'd0, upd_idx}, {26'd0, m_upd_idx});
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, m_upd_taken});
      end
    end
  end

  task automatic drive(input bit pv, input int idx, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit rv, input bit rtk,
                       input logic [31:0] rtg);
    push_valid = pv; push_idx = IDX_W'(idx); push_pc = pc; push_taken = tk;
    push_target = tg; res_valid = rv; res_taken = rtk; res_target = rtg;
  endtask

  task automatic step();
    m_eval();
    @(posedge clk);
    m_apply();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    drive(1, idx, pc, tk, tg, 0, 0, 0);
    step();
  endtask

  task automatic resolve(input bit rtk, input logic [31:0] rtg);
    drive(0, 0, 0, 0, 0, 1, rtk, rtg);
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst push_ready", {31'd0, push_ready}, 32'd0);
    chk("rst count", {29'd0, count}, 32'd0);
    chk("rst flush", {31'd0, flush}, 32'd0);
    chk("rst upd_en", {31'd0, upd_en}, 32'd0);
    chk("rst redirect", redirect_pc, 32'd0);
    chk("rst err", {31'd0, err_underflow}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first ready", {31'd0, push_ready}, 32'd1);

    // Fill, then overfill and push-at-full with a resolve.
    for (int i = 1; i <= 4; i++) push(i, 32'h10 * i, 0, 32'h1000);
    push(9, 32'h90, 0, 32'h1000);
    chk("full count", {29'd0, count}, 32'd4);
    chk("full ready", {31'd0, push_ready}, 32'd0);
    drive(1, 9, 32'h90, 0, 0, 1, 0, 0);
    step();
    chk("full+res count", {29'd0, count}, 32'd3);
    chk("drain idx1", {26'd0, upd_idx}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      resolve(0, 0);
      chk("drain order", {26'd0, upd_idx}, i);
    end
    chk("drained count", {29'd0, count}, 32'd0);

    // Resolve while empty.
    resolve(1, 32'h44);
    chk("uf upd_en", {31'd0, upd_en}, 32'd0);
    chk("uf flush", {31'd0, flush}, 32'd0);
    chk("uf err", {31'd0, err_underflow}, 32'd1);
    idle();
    chk("uf err sticky", {31'd0, err_underflow}, 32'd1);

    // Correct taken resolve.
    push(5, 32'h100, 1, 32'h200);
    push(6, 32'h300, 0, 32'h0);
    resolve(1, 32'h200);
    chk("ok upd_en", {31'd0, upd_en}, 32'd1);
    chk("ok upd_idx", {26'd0, upd_idx}, 32'd5);
    chk("ok upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("ok flush", {31'd0, flush}, 32'd0);
    chk("ok count", {29'd0, count}, 32'd1);
    resolve(0, 0);

    // Direction mispredict, not-taken fallthrough.
    push(7, 32'h100, 1, 32'h200);
    resolve(0, 0);
    chk("mp flush", {31'd0, flush}, 32'd1);
    chk("mp redirect", redirect_pc, 32'h104);
    chk("mp upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("mp count", {29'd0, count}, 32'd0);
    chk("mp ready", {31'd0, push_ready}, 32'd0);
    idle();
    chk("mp hold redirect", redirect_pc, 32'h104);
    chk("mp flush drop", {31'd0, flush}, 32'd0);

    // Mispredict with a concurrent push, three deep.
    push(8, 32'h40, 0, 32'h0);
    push(9, 32'h44, 0, 32'h0);
    push(10, 32'h48, 0, 32'h0);
    drive(1, 11, 32'h4c, 0, 0, 1, 1, 32'h80);
    step();
    chk("mp3 flush", {31'd0, flush}, 32'd1);
    chk("mp3 redirect", redirect_pc, 32'h80);
    chk("mp3 count", {29'd0, count}, 32'd0);
    idle();
    chk("mp3 push dropped", {29'd0, count}, 32'd0);

    // Target mispredict.
    push(12, 32'h500, 1, 32'h200);
    resolve(1, 32'h300);
    chk("tgt redirect", redirect_pc, 32'h300);
    idle();

    // Simultaneous push and correct resolve.
    push(13, 32'h600, 0, 0);
    push(14, 32'h604, 0, 0);
    drive(1, 15, 32'h608, 0, 0, 1, 0, 0);
    step();
    chk("sim count", {29'd0, count}, 32'd2);
    chk("sim idx", {26'd0, upd_idx}, 32'd13);
    resolve(0, 0);
    chk("sim order 14", {26'd0, upd_idx}, 32'd14);
    resolve(0, 0);
    chk("sim order 15", {26'd0, upd_idx}, 32'd15);

    // pc+4 wraps at 32 bits.
    push(16, 32'hFFFF_FFFC, 1, 32'h10);
    resolve(0, 0);
    chk("wrap redirect", redirect_pc, 32'h0);
    idle();

    // Reset landing on a pending flush.
    push(17, 32'h700, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h900);
    m_eval();
    @(posedge clk);
    m_apply();
    #2;
    chk("pre-rst flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid-rst flush", {31'd0, flush}, 32'd0);
    chk("mid-rst upd_en", {31'd0, upd_en}, 32'd0);
    chk("mid-rst count", {29'd0, count}, 32'd0);
    chk("mid-rst err", {31'd0, err_underflow}, 32'd0);
    chk("mid-rst ready", {31'd0, push_ready}, 32'd0);
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
